// File: rtl/enemy_pkg.sv
// Shared encodings, per-type stat table and arithmetic helpers for the enemy pool.
package enemy_pkg;

    typedef enum logic [1:0] {
        TypeDefault = 2'd0,
        TypeLight   = 2'd1,
        TypeMedium  = 2'd2,
        TypeHeavy   = 2'd3
    } enemy_type_e;

    typedef enum logic [2:0] {
        StIdle   = 3'b001,
        StDeploy = 3'b010,
        StAlive  = 3'b100
    } slot_state_e;

    localparam int unsigned HpLight      = 100;
    localparam int unsigned HpMedium     = 180;
    localparam int unsigned HpHeavy      = 255;
    localparam int unsigned PowerLight   = 15;
    localparam int unsigned PowerMedium  = 16;
    localparam int unsigned PowerHeavy   = 133;
    localparam int unsigned PeriodLight  = 1;
    localparam int unsigned PeriodMedium = 2;
    localparam int unsigned PeriodHeavy  = 4;

    // The scheduler may emit type 0; it behaves as the light type.
    function automatic enemy_type_e norm_type(input logic [1:0] t);
        return (t == 2'd0) ? TypeLight : enemy_type_e'(t);
    endfunction

    function automatic int unsigned type_hp(input enemy_type_e t);
        case (t)
            TypeMedium: return HpMedium;
            TypeHeavy:  return HpHeavy;
            default:    return HpLight;
        endcase
    endfunction

    function automatic int unsigned type_power(input enemy_type_e t);
        case (t)
            TypeMedium: return PowerMedium;
            TypeHeavy:  return PowerHeavy;
            default:    return PowerLight;
        endcase
    endfunction

    function automatic int unsigned type_period(input enemy_type_e t);
        case (t)
            TypeMedium: return PeriodMedium;
            TypeHeavy:  return PeriodHeavy;
            default:    return PeriodLight;
        endcase
    endfunction

    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned max_val);
        int unsigned sum;
        sum = a + b;
        return (sum > max_val) ? max_val : sum;
    endfunction

endpackage

// File: rtl/enemy_slot.sv
// One enemy slot: lifecycle FSM plus position, health, power and move divider.
module enemy_slot
    import enemy_pkg::*;
#(
    parameter int unsigned POS_W   = 9,
    parameter int unsigned HP_W    = 8,
    parameter int unsigned DMG_W   = 8,
    parameter int unsigned MAX_POS = 511
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             deploy,
    input  logic [1:0]       deploy_type,
    input  logic             move_tick,
    input  logic [POS_W-1:0] unit_front,
    input  logic             hit,
    input  logic [DMG_W-1:0] damage_in,
    output logic             alive,
    output logic             idle,
    output logic             kill,
    output logic             attack,
    output logic [POS_W-1:0] pos,
    output logic [DMG_W-1:0] power
);

    localparam int unsigned      HpMax  = (2 ** HP_W) - 1;
    localparam int unsigned      DmgMax = (2 ** DMG_W) - 1;
    localparam logic [POS_W-1:0] MaxPos = POS_W'(MAX_POS);

    slot_state_e      state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [HP_W-1:0]  hp_q, hp_d;
    logic [DMG_W-1:0] power_q, power_d;
    logic [2:0]       period_q, period_d;
    logic [2:0]       div_q, div_d;
    logic             step;
    enemy_type_e      load_type;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            pos_q    <= '0;
            hp_q     <= '0;
            power_q  <= '0;
            period_q <= '0;
            div_q    <= '0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            hp_q     <= hp_d;
            power_q  <= power_d;
            period_q <= period_d;
            div_q    <= div_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        hp_d      = hp_q;
        power_d   = power_q;
        period_d  = period_q;
        div_d     = div_q;
        load_type = norm_type(deploy_type);
        unique case (state_q)
            StIdle: begin
                if (deploy) begin
                    state_d  = StDeploy;
                    pos_d    = '0;
                    div_d    = '0;
                    hp_d     = HP_W'(sat_add(type_hp(load_type), 0, HpMax));
                    power_d  = DMG_W'(sat_add(type_power(load_type), 0, DmgMax));
                    period_d = 3'(type_period(load_type));
                end
            end
            StDeploy: state_d = StAlive;
            StAlive: begin
                if (kill) begin
                    state_d  = StIdle;
                    pos_d    = '0;
                    hp_d     = '0;
                    power_d  = '0;
                    period_d = '0;
                    div_d    = '0;
                end else begin
                    if (hit) begin
                        hp_d = HP_W'(32'(hp_q) - 32'(damage_in));
                    end
                    if (move_tick) begin
                        div_d = step ? 3'd0 : div_q + 3'd1;
                    end
                    if (step && !attack) begin
                        pos_d = pos_q + POS_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A lethal hit pre-empts any move or attack in the same cycle.
    always_comb begin
        alive  = (state_q == StAlive);
        idle   = (state_q == StIdle);
        kill   = alive && hit && (32'(hp_q) <= 32'(damage_in));
        step   = alive && move_tick && !kill && (div_q == period_q - 3'd1);
        attack = step && !((unit_front > pos_q) && (pos_q < MaxPos));
        pos    = pos_q;
        power  = power_q;
    end

endmodule

// File: rtl/enemy_pool.sv
// Pool of concurrent enemies: spawn allocation, front tracking, damage routing and kill stats.
module enemy_pool
    import enemy_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned POS_W     = 9,
    parameter int unsigned HP_W      = 8,
    parameter int unsigned DMG_W     = 8,
    parameter int unsigned MAX_POS   = 511,
    localparam int unsigned SlotW    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spawn_valid,
    input  logic [1:0]           spawn_type,
    output logic                 spawn_ready,
    input  logic                 move_tick,
    input  logic                 damage_valid,
    input  logic [DMG_W-1:0]     damage_in,
    input  logic [POS_W-1:0]     unit_front,
    output logic                 front_valid,
    output logic [POS_W-1:0]     front_pos,
    output logic [SlotW-1:0]     front_slot,
    output logic [DMG_W-1:0]     damage_out,
    output logic [NUM_SLOTS-1:0] alive_mask,
    output logic                 kill_pulse,
    output logic [7:0]           kill_count
);

    localparam int unsigned DmgMax = (2 ** DMG_W) - 1;

    logic [NUM_SLOTS-1:0] deploy, hit, alive, idle, kill, attack;
    logic [POS_W-1:0]     slot_pos [NUM_SLOTS];
    logic [DMG_W-1:0]     slot_power [NUM_SLOTS];

    logic                 found;
    logic                 best_valid;
    logic [POS_W-1:0]     best_pos;
    logic [SlotW-1:0]     best_slot;
    int unsigned          dmg_acc;

    logic                 front_valid_q;
    logic [POS_W-1:0]     front_pos_q;
    logic [SlotW-1:0]     front_slot_q;
    logic [DMG_W-1:0]     damage_q;
    logic                 kill_pulse_q;
    logic [7:0]           kill_count_q;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        enemy_slot #(
            .POS_W  (POS_W),
            .HP_W   (HP_W),
            .DMG_W  (DMG_W),
            .MAX_POS(MAX_POS)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .deploy     (deploy[g]),
            .deploy_type(spawn_type),
            .move_tick  (move_tick),
            .unit_front (unit_front),
            .hit        (hit[g]),
            .damage_in  (damage_in),
            .alive      (alive[g]),
            .idle       (idle[g]),
            .kill       (kill[g]),
            .attack     (attack[g]),
            .pos        (slot_pos[g]),
            .power      (slot_power[g])
        );
    end

    // Allocation and damage routing.
    always_comb begin
        deploy = '0;
        hit    = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (spawn_valid && idle[i] && !found) begin
                deploy[i] = 1'b1;
                found     = 1'b1;
            end
        end
        if (damage_valid && front_valid_q) begin
            hit[front_slot_q] = 1'b1;
        end
    end

    // Slots dying this cycle are excluded so the front never points at an IDLE slot.
    always_comb begin
        best_valid = 1'b0;
        best_pos   = '0;
        best_slot  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (alive[i] && !kill[i] && (!best_valid || slot_pos[i] > best_pos)) begin
                best_valid = 1'b1;
                best_pos   = slot_pos[i];
                best_slot  = SlotW'(i);
            end
        end
    end

    always_comb begin
        dmg_acc = 0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (attack[i]) begin
                dmg_acc = sat_add(dmg_acc, 32'(slot_power[i]), DmgMax);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front_valid_q <= 1'b0;
            front_pos_q   <= '0;
            front_slot_q  <= '0;
            damage_q      <= '0;
            kill_pulse_q  <= 1'b0;
            kill_count_q  <= '0;
        end else begin
            front_valid_q <= best_valid;
            front_pos_q   <= best_pos;
            front_slot_q  <= best_slot;
            kill_pulse_q  <= |kill;
            if (move_tick) begin
                damage_q <= DMG_W'(dmg_acc);
            end
            if (|kill) begin
                kill_count_q <= 8'(sat_add(32'(kill_count_q), 1, 255));
            end
        end
    end

    assign spawn_ready = |idle;
    assign alive_mask  = alive;
    assign front_valid = front_valid_q;
    assign front_pos   = front_pos_q;
    assign front_slot  = front_slot_q;
    assign damage_out  = damage_q;
    assign kill_pulse  = kill_pulse_q;
    assign kill_count  = kill_count_q;

endmodule

// File: tb/tb_enemy_pool.sv
// Self-checking bench for enemy_pool: directed scenarios plus a randomized run against a
// slot-level reference model.
module tb_enemy_pool;

    localparam int NS = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spawn_valid = 1'b0;
    logic [1:0] spawn_type = 2'd0;
    logic       spawn_ready;
    logic       move_tick = 1'b0;
    logic       damage_valid = 1'b0;
    logic [7:0] damage_in = 8'd0;
    logic [8:0] unit_front = 9'd0;
    logic       front_valid;
    logic [8:0] front_pos;
    logic [1:0] front_slot;
    logic [7:0] damage_out;
    logic [3:0] alive_mask;
    logic       kill_pulse;
    logic [7:0] kill_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: 0 idle, 1 deploy, 2 alive; ticks counts move_ticks seen while alive.
    int m_state[NS], m_pos[NS], m_hp[NS], m_pow[NS], m_per[NS], m_ticks[NS];
    int m_fv, m_fpos, m_fslot, m_dout, m_kp, m_kc;

    enemy_pool #(
        .NUM_SLOTS(NS),
        .POS_W    (9),
        .HP_W     (8),
        .DMG_W    (8),
        .MAX_POS  (511)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .spawn_valid (spawn_valid),
        .spawn_type  (spawn_type),
        .spawn_ready (spawn_ready),
        .move_tick   (move_tick),
        .damage_valid(damage_valid),
        .damage_in   (damage_in),
        .unit_front  (unit_front),
        .front_valid (front_valid),
        .front_pos   (front_pos),
        .front_slot  (front_slot),
        .damage_out  (damage_out),
        .alive_mask  (alive_mask),
        .kill_pulse  (kill_pulse),
        .kill_count  (kill_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_state[i] = 0; m_pos[i] = 0; m_hp[i] = 0; m_pow[i] = 0; m_per[i] = 1; m_ticks[i] = 0;
        end
        m_fv = 0; m_fpos = 0; m_fslot = 0; m_dout = 0; m_kp = 0; m_kc = 0;
    endtask

    function automatic logic [3:0] m_mask();
        logic [3:0] m;
        for (int i = 0; i < NS; i++) m[i] = (m_state[i] == 2);
        return m;
    endfunction

    function automatic logic m_ready();
        logic r;
        r = 1'b0;
        for (int i = 0; i < NS; i++) if (m_state[i] == 0) r = 1'b1;
        return r;
    endfunction

    task automatic model_step(input bit sv, input int st, input bit tk, input bit dv,
                              input int dm, input int uf);
        int victim, target, sum, t;
        bit killed;
        victim = -1;
        killed = 0;
        if (dv && m_fv != 0) begin
            victim = m_fslot;
            if (m_state[victim] == 2 && m_hp[victim] <= dm) killed = 1;
        end
        target = -1;
        if (sv) for (int i = 0; i < NS; i++) if (m_state[i] == 0 && target < 0) target = i;
        m_fv = 0; m_fpos = 0; m_fslot = 0;
        for (int i = 0; i < NS; i++) begin
            if (m_state[i] == 2 && !(killed && i == victim) && (m_fv == 0 || m_pos[i] > m_fpos)) begin
                m_fv = 1; m_fpos = m_pos[i]; m_fslot = i;
            end
        end
        sum = 0;
        for (int i = 0; i < NS; i++) begin
            if (m_state[i] == 0) begin
                if (i == target) begin
                    t = (st == 0) ? 1 : st;
                    m_state[i] = 1; m_pos[i] = 0; m_ticks[i] = 0;
                    m_hp[i]  = (t == 1) ? 100 : (t == 2) ? 180 : 255;
                    m_pow[i] = (t == 1) ? 15 : (t == 2) ? 16 : 133;
                    m_per[i] = (t == 1) ? 1 : (t == 2) ? 2 : 4;
                end
            end else if (m_state[i] == 1) begin
                m_state[i] = 2;
            end else if (killed && i == victim) begin
                m_state[i] = 0; m_pos[i] = 0;
            end else begin
                if (i == victim) m_hp[i] = m_hp[i] - dm;
                if (tk) begin
                    m_ticks[i]++;
                    if (m_ticks[i] % m_per[i] == 0) begin
                        if (uf > m_pos[i] && m_pos[i] < 511) m_pos[i]++;
                        else sum += m_pow[i];
                    end
                end
            end
        end
        if (tk) m_dout = (sum > 255) ? 255 : sum;
        m_kp = killed ? 1 : 0;
        if (killed && m_kc < 255) m_kc++;
    endtask

    // Drive one cycle of inputs, advance the model, and return at the following negedge.
    task automatic cycle(input bit sv, input int st, input bit tk, input bit dv, input int dm,
                         input int uf);
        spawn_valid  = sv;
        spawn_type   = 2'(st);
        move_tick    = tk;
        damage_valid = dv;
        damage_in    = 8'(dm);
        unit_front   = 9'(uf);
        model_step(sv, st, tk, dv, dm, uf);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        spawn_valid = 0; spawn_type = 0; move_tick = 0; damage_valid = 0; damage_in = 0;
        unit_front = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset_spawn();
        do_reset();
        n_cmp++; if (spawn_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", spawn_ready); end
        n_cmp++; if ({front_valid, front_pos, front_slot, damage_out, alive_mask, kill_pulse, kill_count} !== '0) begin
            n_bad++; $display("FAIL rst_outputs: got fv=%b fp=%0d fs=%0d do=%0d am=%b kp=%b kc=%0d want all 0",
                              front_valid, front_pos, front_slot, damage_out, alive_mask, kill_pulse, kill_count);
        end
        cycle(1, 2, 0, 0, 0, 0);
        n_cmp++; if (alive_mask !== 4'b0000) begin n_bad++; $display("FAIL spawn_deploy_mask: got %b want 0000", alive_mask); end
        cycle(0, 0, 0, 0, 0, 0);
        n_cmp++; if (alive_mask !== 4'b0001) begin n_bad++; $display("FAIL spawn_alive_mask: got %b want 0001", alive_mask); end
        n_cmp++; if (front_valid !== 1'b0) begin n_bad++; $display("FAIL spawn_front_early: got %b want 0", front_valid); end
        cycle(0, 0, 0, 0, 0, 0);
        n_cmp++; if ({front_valid, front_pos, front_slot} !== {1'b1, 9'd0, 2'd0}) begin
            n_bad++; $display("FAIL spawn_front: got v=%b p=%0d s=%0d want v=1 p=0 s=0", front_valid, front_pos, front_slot);
        end
    endtask

    task automatic test_move_attack();
        int exp_dmg[5] = '{0, 0, 0, 15, 15};
        do_reset();
        cycle(1, 0, 0, 0, 0, 3);  // type 0 behaves as type 1
        cycle(0, 0, 0, 0, 0, 3);
        cycle(0, 0, 0, 0, 0, 3);
        for (int k = 0; k < 5; k++) begin
            cycle(0, 0, 1, 0, 0, 3);
            n_cmp++; if (damage_out !== 8'(exp_dmg[k])) begin
                n_bad++; $display("FAIL move_dmg_tick%0d: got %0d want %0d", k + 1, damage_out, exp_dmg[k]);
            end
        end
        cycle(0, 0, 0, 0, 0, 3);
        n_cmp++; if (front_pos !== 9'd3) begin n_bad++; $display("FAIL move_stop_pos: got %0d want 3", front_pos); end
        n_cmp++; if (damage_out !== 8'd15) begin n_bad++; $display("FAIL move_dmg_hold: got %0d want 15", damage_out); end
    endtask

    task automatic test_kill();
        do_reset();
        cycle(1, 3, 0, 0, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 100, 0);
        cycle(0, 0, 0, 1, 154, 0);
        n_cmp++; if ({kill_pulse, alive_mask} !== {1'b0, 4'b0001}) begin
            n_bad++; $display("FAIL kill_nonlethal: got kp=%b am=%b want kp=0 am=0001", kill_pulse, alive_mask);
        end
        cycle(0, 0, 0, 1, 1, 0);  // health now exactly equals damage
        n_cmp++; if ({kill_pulse, kill_count} !== {1'b1, 8'd1}) begin
            n_bad++; $display("FAIL kill_pulse: got kp=%b kc=%0d want kp=1 kc=1", kill_pulse, kill_count);
        end
        n_cmp++; if ({alive_mask, front_valid, spawn_ready} !== {4'b0000, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL kill_state: got am=%b fv=%b rdy=%b want am=0000 fv=0 rdy=1",
                              alive_mask, front_valid, spawn_ready);
        end
        cycle(0, 0, 0, 1, 255, 0);  // no front: ignored
        n_cmp++; if ({kill_pulse, kill_count} !== {1'b0, 8'd1}) begin
            n_bad++; $display("FAIL kill_once: got kp=%b kc=%0d want kp=0 kc=1", kill_pulse, kill_count);
        end
    endtask

    task automatic test_full_pool();
        do_reset();
        cycle(1, 3, 0, 0, 0, 5);
        cycle(1, 3, 0, 0, 0, 5);
        cycle(1, 1, 0, 0, 0, 5);
        cycle(1, 3, 0, 0, 0, 5);
        n_cmp++; if (spawn_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", spawn_ready); end
        cycle(1, 2, 0, 0, 0, 5);
        n_cmp++; if (alive_mask !== 4'b1111) begin n_bad++; $display("FAIL full_mask: got %b want 1111", alive_mask); end
        cycle(0, 0, 1, 0, 0, 5);  // only the period-1 enemy in slot 2 steps forward
        cycle(0, 0, 0, 0, 0, 5);
        n_cmp++; if ({front_slot, front_pos} !== {2'd2, 9'd1}) begin
            n_bad++; $display("FAIL full_front: got s=%0d p=%0d want s=2 p=1", front_slot, front_pos);
        end
        cycle(1, 1, 0, 1, 100, 5);
        n_cmp++; if ({kill_pulse, alive_mask, spawn_ready} !== {1'b1, 4'b1011, 1'b1}) begin
            n_bad++; $display("FAIL full_kill: got kp=%b am=%b rdy=%b want kp=1 am=1011 rdy=1",
                              kill_pulse, alive_mask, spawn_ready);
        end
        n_cmp++; if ({front_valid, front_slot} !== {1'b1, 2'd0}) begin
            n_bad++; $display("FAIL full_front_after: got v=%b s=%0d want v=1 s=0", front_valid, front_slot);
        end
        cycle(1, 2, 0, 0, 0, 5);
        n_cmp++; if ({spawn_ready, alive_mask} !== {1'b0, 4'b1011}) begin
            n_bad++; $display("FAIL full_respawn: got rdy=%b am=%b want rdy=0 am=1011", spawn_ready, alive_mask);
        end
        cycle(0, 0, 0, 0, 0, 5);
        n_cmp++; if (alive_mask !== 4'b1111) begin n_bad++; $display("FAIL full_refill: got %b want 1111", alive_mask); end
    endtask

    task automatic test_saturate();
        do_reset();
        repeat (4) cycle(1, 3, 0, 0, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 0, 0);
        repeat (3) cycle(0, 0, 1, 0, 0, 0);
        n_cmp++; if (damage_out !== 8'd0) begin n_bad++; $display("FAIL sat_pre: got %0d want 0", damage_out); end
        cycle(0, 0, 1, 0, 0, 0);
        n_cmp++; if (damage_out !== 8'd255) begin n_bad++; $display("FAIL sat_sum: got %0d want 255", damage_out); end
    endtask

    task automatic test_period_reset();
        int exp_fp[6] = '{0, 0, 1, 1, 2, 2};
        do_reset();
        cycle(1, 2, 0, 0, 0, 2);
        repeat (2) cycle(0, 0, 0, 0, 0, 2);
        for (int k = 0; k < 6; k++) begin
            cycle(0, 0, 1, 0, 0, 2);
            n_cmp++; if (front_pos !== 9'(exp_fp[k])) begin
                n_bad++; $display("FAIL period_pos_tick%0d: got %0d want %0d", k + 1, front_pos, exp_fp[k]);
            end
        end
        n_cmp++; if (damage_out !== 8'd16) begin n_bad++; $display("FAIL period_dmg: got %0d want 16", damage_out); end
        spawn_valid = 1'b1;
        spawn_type  = 2'd1;
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({spawn_ready, front_valid, front_pos, front_slot, damage_out, alive_mask, kill_pulse, kill_count}
                     !== {1'b1, 1'b0, 9'd0, 2'd0, 8'd0, 4'd0, 1'b0, 8'd0}) begin
            n_bad++; $display("FAIL async_reset: got rdy=%b fv=%b fp=%0d fs=%0d do=%0d am=%b kp=%b kc=%0d want rdy=1 rest 0",
                              spawn_ready, front_valid, front_pos, front_slot, damage_out, alive_mask, kill_pulse, kill_count);
        end
        @(negedge clk);
        do_reset();
        cycle(0, 0, 0, 0, 0, 0);
        n_cmp++; if (alive_mask !== 4'b0000) begin n_bad++; $display("FAIL reset_no_spawn: got %b want 0000", alive_mask); end
    endtask

    task automatic test_random();
        bit sv, tk, dv;
        int st, dm, uf;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            sv = ($urandom_range(0, 2) == 0);
            st = $urandom_range(0, 3);
            tk = $urandom_range(0, 1) == 1;
            dv = ($urandom_range(0, 3) == 0);
            dm = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 60) : $urandom_range(0, 255);
            uf = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 12);
            cycle(sv, st, tk, dv, dm, uf);
            n_cmp++; if (spawn_ready !== m_ready()) begin n_bad++; $display("FAIL rnd_ready c%0d: got %b want %b", c, spawn_ready, m_ready()); end
            n_cmp++; if (alive_mask !== m_mask()) begin n_bad++; $display("FAIL rnd_mask c%0d: got %b want %b", c, alive_mask, m_mask()); end
            n_cmp++; if (front_valid !== 1'(m_fv)) begin n_bad++; $display("FAIL rnd_fvalid c%0d: got %b want %0d", c, front_valid, m_fv); end
            n_cmp++; if (front_pos !== 9'(m_fpos)) begin n_bad++; $display("FAIL rnd_fpos c%0d: got %0d want %0d", c, front_pos, m_fpos); end
            n_cmp++; if (front_slot !== 2'(m_fslot)) begin n_bad++; $display("FAIL rnd_fslot c%0d: got %0d want %0d", c, front_slot, m_fslot); end
            n_cmp++; if (damage_out !== 8'(m_dout)) begin n_bad++; $display("FAIL rnd_dmg c%0d: got %0d want %0d", c, damage_out, m_dout); end
            n_cmp++; if (kill_pulse !== 1'(m_kp)) begin n_bad++; $display("FAIL rnd_kpulse c%0d: got %b want %0d", c, kill_pulse, m_kp); end
            n_cmp++; if (kill_count !== 8'(m_kc)) begin n_bad++; $display("FAIL rnd_kcount c%0d: got %0d want %0d", c, kill_count, m_kc); end
        end
    endtask

    initial begin
        model_reset();
        test_reset_spawn();
        test_move_attack();
        test_kill();
        test_full_pool();
        test_saturate();
        test_period_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/enemy_pool.md
Name: enemy_pool

Overview:
- Parametrised successor to the single-enemy unit: manages NUM_SLOTS concurrent enemies in one block.
- Handles spawn allocation, per-type speed and attack, damage routed to the frontmost enemy, and kill accounting.
- Sits between the spawn scheduler and the battlefront calculator.
- Feeds aggregated attack damage and frontmost enemy position to the top level.

Parameters:
- NUM_SLOTS, 4, number of concurrent enemy slots (1..16).
- POS_W, 9, position width in bits.
- HP_W, 8, health width in bits.
- DMG_W, 8, damage/power width in bits.
- MAX_POS, 511, farthest reachable position.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- spawn_valid  in  1  spawn request.
- spawn_type  in  2  enemy type; 0 is treated as 1.
- spawn_ready  out  1  at least one slot is IDLE.
- move_tick  in  1  one-cycle movement/attack strobe.
- damage_valid  in  1  damage strobe.
- damage_in  in  DMG_W  damage applied to the front enemy.
- unit_front  in  POS_W  position of the frontmost player unit.
- front_valid  out  1  at least one enemy is ALIVE.
- front_pos  out  POS_W  position of the frontmost enemy.
- front_slot  out  $clog2(NUM_SLOTS)  index of the frontmost enemy.
- damage_out  out  DMG_W  saturated sum of attacking enemies' power.
- alive_mask  out  NUM_SLOTS  per-slot ALIVE flags.
- kill_pulse  out  1  one-cycle pulse on any death.
- kill_count  out  8  total kills, saturating at 255.

Behaviour:
- Reset values:
  - All slots IDLE; every output 0 except spawn_ready=1.
  - Per-slot position, health, power and move divider counters cleared.
  - A reset asserted mid-operation aborts everything immediately, including any pending death or spawn.
- Per-slot FSM, one-hot: IDLE -> DEPLOY -> ALIVE -> IDLE.
  - IDLE: position=0, contributes nothing.
  - DEPLOY (one cycle): load health, power and move period from the type table; position=0.
  - ALIVE: moves, attacks, takes damage.
- Type table:
  - type1: HP 100, power 15, period 1.
  - type2: HP 180, power 16, period 2.
  - type3: HP 255, power 133, period 4.
  - Values are truncated or saturated to HP_W/DMG_W.
- Spawn:
  - spawn_ready is combinational from current slot states.
  - When spawn_valid & spawn_ready, the lowest-index IDLE slot enters DEPLOY next cycle. One spawn per cycle.
  - spawn_valid while not ready is ignored; no queueing.
  - A slot freed by a death this cycle is not allocatable until the following cycle.
- Move/attack, on move_tick, for each ALIVE slot:
  - The divider counter increments; when it reaches period-1 it wraps to 0 and the slot acts.
  - Act: if unit_front > pos and pos < MAX_POS, pos <= pos+1 (no attack). Otherwise the slot attacks.
  - damage_out is registered the cycle after move_tick: sum of power of attacking slots, saturating at 2^DMG_W-1. It is held until the next move_tick and is 0 if none attacked.
  - A slot in DEPLOY ignores move_tick.
- Front tracking:
  - Registered, 1-cycle latency.
  - front_pos is the maximum pos over ALIVE slots; ties go to the lowest index.
  - With no ALIVE slots: front_valid=0, front_pos=0, front_slot=0.
- Damage:
  - On damage_valid with front_valid=1, damage_in is applied to registered front_slot.
  - If health <= damage_in, the slot goes to IDLE next cycle, kill_pulse=1 for one cycle, and kill_count increments (saturating at 255). Otherwise health <= health - damage_in.
  - damage_valid with front_valid=0 is ignored.
- Simultaneous events:
  - Death and move_tick in the same cycle: death wins; the slot neither moves nor contributes to damage_out.
  - Damage to a slot that is not ALIVE is impossible by construction, because front_slot only points at ALIVE slots.

Decomposition:
- Package enemy_pkg:
  - enemy type encoding.
  - slot state encoding.
  - HP/POWER/MOVE_PERIOD table constants.
  - saturating add helper function.
- Sub-module enemy_slot:
  - one per slot via generate.
  - holds that slot's FSM, pos, health, power and divider.
  - inputs: deploy strobe/type, act, hit/damage.
- enemy_pool holds the allocator, front selector, damage adder and kill counter.

Test Plan:
1. Reset, spawn type2 -> slot0 ALIVE after 2 cycles, alive_mask=0001, pos=0, front_valid=1 one cycle later.
2. Slot0 type1, unit_front=3, five move_ticks -> pos stops at 3; ticks 4-5 give damage_out=15.
3. Type3 at the front, damage_valid with damage_in=255 -> kill_pulse once, kill_count=1, slot IDLE, front_valid=0.
4. Fill all 4 slots -> spawn_ready=0; a further spawn_valid is ignored. Kill slot2, next spawn lands in slot2.
5. Four type3 enemies all attacking, one move_tick -> damage_out=255 (saturated from 532).
6. Type2 slot, move_tick every cycle -> pos advances every 2nd tick. Assert reset mid-run -> all outputs 0, spawn_ready=1.
